// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: widths, ALU fn codes, special opcodes,
// instruction field positions, decode classes and the registered EX bundle.
package alu_pkg;

    localparam int IW = 19;
    localparam int RA = 3;

    localparam int INSTR_IMM_SEL = 18;
    localparam int OP_MSB        = 17;
    localparam int OP_LSB        = 14;
    localparam int RD_MSB        = 13;
    localparam int RD_LSB        = 11;
    localparam int RS_MSB        = 10;
    localparam int RS_LSB        = 8;
    localparam int IMM_MSB       = 7;
    localparam int IMM_LSB       = 0;

    localparam logic [3:0] FN_ADD  = 4'd0;
    localparam logic [3:0] FN_ADDC = 4'd1;
    localparam logic [3:0] FN_SUB  = 4'd2;
    localparam logic [3:0] FN_SUBC = 4'd3;
    localparam logic [3:0] FN_AND  = 4'd4;
    localparam logic [3:0] FN_OR   = 4'd5;
    localparam logic [3:0] FN_XOR  = 4'd6;
    localparam logic [3:0] FN_MASK = 4'd7;
    localparam logic [3:0] FN_SHL  = 4'd8;
    localparam logic [3:0] FN_SHR  = 4'd9;
    localparam logic [3:0] FN_ROL  = 4'd10;
    localparam logic [3:0] FN_ROR  = 4'd11;

    localparam logic [3:0] OP_NOP  = 4'd12;
    localparam logic [3:0] OP_CLRC = 4'd13;
    localparam logic [3:0] OP_SETC = 4'd14;
    localparam logic [3:0] OP_ILL  = 4'd15;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_NOP,
        CLS_CLRC,
        CLS_SETC,
        CLS_ILL
    } op_class_e;

    typedef struct packed {
        logic [3:0]    fn;
        logic [2:0]    sc;
        logic [RA-1:0] rd;
        logic [RA-1:0] rs;
        logic [RA-1:0] rt;
        logic [7:0]    imm;
        logic          imm_sel;
        logic          wb_en;
        logic          upd_z;
        logic          upd_c;
    } ex_bundle_t;

    function automatic logic uses_carry_in(input logic [3:0] fn);
        return (fn == FN_ADDC) || (fn == FN_SUBC);
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Fetch-side (instruction handshake + flush) and EX-side (control bundle, flag
// writeback, architectural flags) interfaces of the ALU issue stage.
interface issue_in_if;
    import alu_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic          flush;
    logic [IW-1:0] instr;

    modport master (output in_valid, instr, flush, input in_ready);
    modport slave  (input in_valid, instr, flush, output in_ready);
endinterface

interface issue_ex_if;
    import alu_pkg::*;

    logic          out_valid;
    logic          out_ready;
    logic [3:0]    fn;
    logic [2:0]    sc;
    logic          cin;
    logic [RA-1:0] rd;
    logic [RA-1:0] rs;
    logic [RA-1:0] rt;
    logic [7:0]    imm;
    logic          imm_sel;
    logic          wb_en;
    logic          upd_z;
    logic          upd_c;
    logic          flag_we_z;
    logic          flag_we_c;
    logic          alu_zero;
    logic          alu_cout;
    logic          z_flag;
    logic          c_flag;
    logic          illegal;

    // Stage side drives the bundle and flags; EX side returns ready and flag writeback.
    modport master (
        output out_valid, fn, sc, cin, rd, rs, rt, imm, imm_sel, wb_en, upd_z, upd_c,
        output z_flag, c_flag, illegal,
        input  out_ready, flag_we_z, flag_we_c, alu_zero, alu_cout
    );
    modport slave (
        input  out_valid, fn, sc, cin, rd, rs, rt, imm, imm_sel, wb_en, upd_z, upd_c,
        input  z_flag, c_flag, illegal,
        output out_ready, flag_we_z, flag_we_c, alu_zero, alu_cout
    );
endinterface

// File: rtl/alu_issue_decode.sv
// Combinational instruction decode: field extraction plus fn/wb/flag-update controls
// and an op class. Build option ISSUE_ILLEGAL_TRAP_EN makes op 15 decode as illegal.
module alu_issue_decode
    import alu_pkg::*;
(
    input  logic [IW-1:0] instr_i,
    output ex_bundle_t    bundle_o,
    output op_class_e     class_o
);

    logic [3:0] op;
    logic [7:0] imm8;

    assign op   = instr_i[OP_MSB:OP_LSB];
    assign imm8 = instr_i[IMM_MSB:IMM_LSB];

    always_comb begin
        bundle_o         = '0;
        bundle_o.sc      = imm8[2:0];
        bundle_o.rd      = instr_i[RD_MSB:RD_LSB];
        bundle_o.rs      = instr_i[RS_MSB:RS_LSB];
        bundle_o.rt      = imm8[RA-1:0];
        bundle_o.imm     = imm8;
        bundle_o.imm_sel = instr_i[INSTR_IMM_SEL];
        bundle_o.fn      = FN_ADD;
        class_o          = CLS_NOP;

        if (op <= FN_ROR) begin
            class_o        = CLS_ALU;
            bundle_o.fn    = op;
            bundle_o.wb_en = 1'b1;
            bundle_o.upd_z = 1'b1;
            // Logic ops leave carry alone; arithmetic and shifts both produce one.
            bundle_o.upd_c = !((op >= FN_AND) && (op <= FN_MASK));
        end else begin
            case (op)
                OP_CLRC: class_o = CLS_CLRC;
                OP_SETC: class_o = CLS_SETC;
                OP_ILL: begin
`ifdef ISSUE_ILLEGAL_TRAP_EN
                    class_o = CLS_ILL;
`else
                    class_o = CLS_NOP;
`endif
                end
                default: class_o = CLS_NOP;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: one register slice toward EX, Z/C flag register, carry-in forwarding
// and ADDC/SUBC interlock. Build option ISSUE_ILLEGAL_TRAP_EN enables the sticky op-15 trap.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    issue_in_if.slave  fetch,
    issue_ex_if.master ex
);

    ex_bundle_t dec_bundle;
    op_class_e  dec_class;

    logic       out_valid_q, out_valid_d;
    ex_bundle_t bundle_q, bundle_d;
    logic       cin_q, cin_d;
    logic       z_q, z_d;
    logic       c_q, c_d;

    logic       trap_active;
    logic       carry_op;
    logic       carry_hazard;
    logic       in_ready;
    logic       accept;
    logic       c_fwd;

    alu_issue_decode u_decode (
        .instr_i  (fetch.instr),
        .bundle_o (dec_bundle),
        .class_o  (dec_class)
    );

    always_comb begin
        carry_op     = (dec_class == CLS_ALU) && uses_carry_in(dec_bundle.fn);
        // The bundle in EX will still rewrite C; a carry consumer must wait for it.
        carry_hazard = out_valid_q && bundle_q.upd_c && !ex.flag_we_c;
        in_ready     = (!out_valid_q || ex.out_ready) && !(carry_op && carry_hazard) && !trap_active;
        accept       = fetch.in_valid && in_ready && !fetch.flush;
        c_fwd        = ex.flag_we_c ? ex.alu_cout : c_q;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        bundle_d    = bundle_q;
        cin_d       = cin_q;
        if (fetch.flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = (dec_class != CLS_ILL);
            if (dec_class != CLS_ILL) begin
                bundle_d = dec_bundle;
                cin_d    = carry_op & c_fwd;
            end
        end else if (ex.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        z_d = z_q;
        c_d = c_q;
        if (ex.flag_we_z) begin
            z_d = ex.alu_zero;
        end
        // CLRC/SETC take effect at issue and override a coincident writeback.
        if (accept && (dec_class == CLS_CLRC)) begin
            c_d = 1'b0;
        end else if (accept && (dec_class == CLS_SETC)) begin
            c_d = 1'b1;
        end else if (ex.flag_we_c) begin
            c_d = ex.alu_cout;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
            cin_q       <= 1'b0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
            cin_q       <= cin_d;
            z_q         <= z_d;
            c_q         <= c_d;
        end
    end

`ifdef ISSUE_ILLEGAL_TRAP_EN
    logic trap_q, trap_d;

    always_comb begin
        trap_d = trap_q;
        if (fetch.flush) begin
            trap_d = 1'b0;
        end else if (accept && (dec_class == CLS_ILL)) begin
            trap_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= trap_d;
        end
    end

    assign trap_active = trap_q;
`else
    assign trap_active = 1'b0;
`endif

    assign fetch.in_ready = in_ready;

    assign ex.out_valid = out_valid_q;
    assign ex.fn        = bundle_q.fn;
    assign ex.sc        = bundle_q.sc;
    assign ex.cin       = cin_q;
    assign ex.rd        = bundle_q.rd;
    assign ex.rs        = bundle_q.rs;
    assign ex.rt        = bundle_q.rt;
    assign ex.imm       = bundle_q.imm;
    assign ex.imm_sel   = bundle_q.imm_sel;
    assign ex.wb_en     = bundle_q.wb_en;
    assign ex.upd_z     = bundle_q.upd_z;
    assign ex.upd_c     = bundle_q.upd_c;
    assign ex.z_flag    = z_q;
    assign ex.c_flag    = c_q;
    assign ex.illegal   = trap_active;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue pipeline stage that drives the 8-bit ALU's control interface: fn, sc and Cin.
- Accepts 19-bit instructions from fetch over a valid/ready handshake and registers the decoded ALU controls toward EX.
- Holds the architectural Z/C flag register, updated by EX flag writeback.
- Supplies Cin from the C flag, forwarding a same-cycle writeback.

Parameters:
- IW, 19: instruction width.
- RA, 3: register address width (8 registers).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  fetch holds a valid instruction.
- in_ready  out  1  stage accepts an instruction this cycle.
- instr  in  IW  layout [18] imm_sel, [17:14] op, [13:11] rd, [10:8] rs, [7:0] imm8; when imm_sel=0, rt=imm8[2:0].
- flush  in  1  squash the held and incoming instruction.
- out_valid  out  1  registered EX-bound bundle is valid.
- out_ready  in  1  EX accepts the bundle.
- fn  out  4  ALU function code; same encoding as the ALU: ADD=0 ADDC=1 SUB=2 SUBC=3 AND=4 OR=5 XOR=6 MASK=7 SHL=8 SHR=9 ROL=10 ROR=11.
- sc  out  3  shift count, equal to imm8[2:0].
- cin  out  1  carry-in for ADDC/SUBC; 0 for all other ops.
- rd, rs, rt  out  RA  register addresses.
- imm  out  8  immediate operand.
- imm_sel  out  1  B operand source is the immediate.
- wb_en  out  1  EX result is written to rd.
- upd_z, upd_c  out  1  EX returns this flag.
- flag_we_z, flag_we_c  in  1  EX flag writeback strobes.
- alu_zero, alu_cout  in  1  EX flag values.
- z_flag, c_flag  out  1  architectural flags.
- illegal  out  1  illegal-opcode indicator.

Behaviour:
- Reset (rst=0, asynchronous): out_valid=0, fn=0, sc=0, cin=0, rd/rs/rt=0, imm=0, imm_sel=0, wb_en=0, upd_z=0, upd_c=0, z_flag=0, c_flag=0, illegal=0.
- Reset asserted mid-transfer drops the held bundle; there is no replay.
- Handshake:
  - in_ready = !out_valid || out_ready (single register stage, no skid buffer).
  - A transfer occurs when in_valid && in_ready. Latency is 1 cycle: the bundle is visible at out_valid on the next edge.
  - The bundle holds stable while out_valid && !out_ready.
  - out_valid clears when out_ready is high and no new transfer occurs.
- Flush: on the next edge out_valid=0 and any same-cycle incoming instruction is discarded. Flush wins over in_valid. The flag register is not affected.
- Decode by op:
  - op 0-11: fn=op, wb_en=1.
  - op 0-3 (arithmetic): upd_z=1, upd_c=1.
  - op 4-7 (logic): upd_z=1, upd_c=0.
  - op 8-11 (shift/rotate): upd_z=1, upd_c=1, sc=imm8[2:0]; sc=0 is legal and passes A through.
  - op 12 (NOP): out_valid=1, wb_en=0, upd_z=0, upd_c=0, fn=ADD.
  - op 13 (CLRC): bubble to EX with wb_en=0; c_flag is cleared at the issue edge.
  - op 14 (SETC): bubble to EX with wb_en=0; c_flag is set at the issue edge.
  - op 15: illegal (see Optional Feature).
- Flags:
  - z_flag <= alu_zero when flag_we_z; c_flag <= alu_cout when flag_we_c.
  - CLRC/SETC at issue have priority over a same-edge flag_we_c.
- Cin:
  - cin is registered with the bundle: the C flag value for ADDC/SUBC, else 0.
  - Forwarding: if flag_we_c is high in the issuing cycle, cin uses alu_cout instead of the stale c_flag.
  - Interlock: if the instruction currently in EX has upd_c=1 and its writeback has not yet arrived (out_valid && upd_c && !flag_we_c), a new ADDC/SUBC is held: in_ready=0 for ADDC/SUBC only.

Optional Feature:
- ISSUE_ILLEGAL_TRAP_EN defined:
  - op 15 sets sticky illegal=1, emits no bundle, and forces in_ready=0.
  - Only rst or flush clears the trap.
- Undefined:
  - op 15 decodes as NOP; illegal stays 0.

Decomposition:
- Shared package alu_pkg: the fn code constants (ADD..ROR), op constants NOP/CLRC/SETC/ILL, and the instruction field bit positions.
- One natural sub-module: alu_issue_decode, purely combinational (instr -> fn, sc, wb_en, upd_z, upd_c, class). The stage registers, flags and handshake stay in the top module.

Test Plan:
- Reset then ADD r1,r2,r3 (instr=0x0_0A03, op=0, rd=1, rs=2, rt=3) -> next cycle out_valid=1, fn=0, rd=1, rs=2, rt=3, wb_en=1, upd_c=1, cin=0.
- SETC, then ADDC -> c_flag=1 after SETC; the ADDC bundle has fn=1 and cin=1.
- ADDC issued while flag_we_c=1 with alu_cout=1 and c_flag=0 -> cin=1 (forwarded); next cycle c_flag=1.
- out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, bundle stable; out_ready=1 -> the next instruction appears one cycle later.
- flush together with in_valid=1 -> out_valid=0 next cycle; z_flag and c_flag unchanged.
- op 15 -> with ISSUE_ILLEGAL_TRAP_EN: illegal=1, in_ready=0 until flush. Without it: NOP bundle emitted, illegal=0.
